// File: rtl/operand_fetch_stage_pkg.sv
// Shared types for the operand fetch stage: forwarding records, operand-select
// encodings, instruction-id sentinel and the hold-state enum.
package operand_fetch_stage_pkg;

  localparam int unsigned OPF_XLEN = 32;
  localparam int unsigned OPF_RS_W = 5;
  localparam int unsigned IID_W    = 8;

  typedef logic [OPF_XLEN-1:0] UIntX;
  typedef logic [OPF_XLEN-1:0] Addr;
  typedef logic [31:0]         Inst;
  typedef logic [IID_W-1:0]    IId;

  localparam IId IID_X = '1;

  typedef enum logic [1:0] {
    OP1_X,
    OP1_RS1,
    OP1_PC,
    OP1_IMZ
  } Op1Sel;

  typedef enum logic [2:0] {
    OP2_X,
    OP2_RS2W,
    OP2_IMI,
    OP2_IMS,
    OP2_IMJ,
    OP2_IMU
  } Op2Sel;

  typedef struct packed {
    Op1Sel      op1_sel;
    Op2Sel      op2_sel;
    logic [3:0] fn;
  } Ctrl;

  typedef struct packed {
    logic                valid;
    logic [OPF_RS_W-1:0] addr;
    logic                fwdable;
    UIntX                wdata;
  } FwCtrl;

  typedef enum logic [1:0] {
    OPF_IDLE,
    OPF_HAZ,
    OPF_WAIT
  } OpfState;

endpackage

// File: rtl/operand_fetch_stage_forward_mux.sv
// Resolves one source register against the priority-ordered forwarding
// sources; falls back to the register file value when nothing matches.
module operand_forward_mux
  import operand_fetch_stage_pkg::*;
#(
  parameter int unsigned FW_NUM = 4,
  parameter int unsigned XLEN   = OPF_XLEN,
  parameter int unsigned RS_W   = OPF_RS_W
) (
  input  logic [RS_W-1:0] rs,
  input  logic [XLEN-1:0] reg_data,
  input  FwCtrl           fw [FW_NUM],
  output logic [XLEN-1:0] data,
  output logic            blocked
);

  // Lowest index wins: once a match is found later entries are ignored.
  always_comb begin
    logic found;
    found   = 1'b0;
    data    = reg_data;
    blocked = 1'b0;
    for (int unsigned k = 0; k < FW_NUM; k++) begin
      if (!found && fw[k].valid && (RS_W'(fw[k].addr) == rs) && (rs != '0)) begin
        found   = 1'b1;
        data    = XLEN'(fw[k].wdata);
        blocked = !fw[k].fwdable;
      end
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Registered operand-select stage between Decode and Execute.
// Optional hazard-stall counter: define OPF_PERFCNT_EN to build stall_cycles.
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  parameter int unsigned XLEN    = OPF_XLEN,
  parameter int unsigned FW_NUM  = 4,
  parameter int unsigned REG_NUM = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [XLEN-1:0] regfile [REG_NUM],
  input  FwCtrl           fw [FW_NUM],
  input  logic            in_valid,
  output logic            in_ready,
  input  Addr             in_pc,
  input  Inst             in_inst,
  input  IId              in_inst_id,
  input  Ctrl             in_ctrl,
  input  logic [XLEN-1:0] in_imm_i,
  input  logic [XLEN-1:0] in_imm_s,
  input  logic [XLEN-1:0] in_imm_j,
  input  logic [XLEN-1:0] in_imm_u,
  input  logic [XLEN-1:0] in_imm_z,
  output logic            out_valid,
  input  logic            out_ready,
  output Addr             out_pc,
  output Inst             out_inst,
  output IId              out_inst_id,
  output Ctrl             out_ctrl,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [XLEN-1:0] out_rs2,
  output logic            is_datahazard
`ifdef OPF_PERFCNT_EN
  ,
  output logic [31:0]     stall_cycles
`endif
);

  localparam int unsigned RS_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  OpfState state, state_next;

  Addr             hold_pc;
  Inst             hold_inst;
  IId              hold_id;
  Ctrl             hold_ctrl;
  logic [XLEN-1:0] hold_imm_i, hold_imm_s, hold_imm_j, hold_imm_u, hold_imm_z;

  logic            held, hazard, launch, capture;
  logic [RS_W-1:0] rs1, rs2;
  logic [XLEN-1:0] rs1_data, rs2_data, op1, op2;
  logic            rs1_blocked, rs2_blocked;

  assign rs1 = hold_inst[15 +: RS_W];
  assign rs2 = hold_inst[20 +: RS_W];

  operand_forward_mux #(
    .FW_NUM (FW_NUM),
    .XLEN   (XLEN),
    .RS_W   (RS_W)
  ) u_rs1_mux (
    .rs       (rs1),
    .reg_data (regfile[rs1]),
    .fw       (fw),
    .data     (rs1_data),
    .blocked  (rs1_blocked)
  );

  operand_forward_mux #(
    .FW_NUM (FW_NUM),
    .XLEN   (XLEN),
    .RS_W   (RS_W)
  ) u_rs2_mux (
    .rs       (rs2),
    .reg_data (regfile[rs2]),
    .fw       (fw),
    .data     (rs2_data),
    .blocked  (rs2_blocked)
  );

  assign held          = (state != OPF_IDLE);
  assign hazard        = held & (rs1_blocked | rs2_blocked);
  assign is_datahazard = hazard;
  assign launch        = held & !hazard & (!out_valid | out_ready);
  assign in_ready      = !held | launch;
  assign capture       = in_valid & in_ready & !flush;

  // A fresh capture enters WAIT; its hazard status is known the next cycle.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = OPF_IDLE;
    end else if (capture) begin
      state_next = OPF_WAIT;
    end else if (launch) begin
      state_next = OPF_IDLE;
    end else if (held) begin
      state_next = hazard ? OPF_HAZ : OPF_WAIT;
    end
  end

  always_comb begin
    op1 = '0;
    unique case (hold_ctrl.op1_sel)
      OP1_RS1: op1 = rs1_data;
      OP1_PC:  op1 = XLEN'(hold_pc);
      OP1_IMZ: op1 = hold_imm_z;
      default: op1 = '0;
    endcase
  end

  always_comb begin
    op2 = '0;
    unique case (hold_ctrl.op2_sel)
      OP2_RS2W: op2 = rs2_data;
      OP2_IMI:  op2 = hold_imm_i;
      OP2_IMS:  op2 = hold_imm_s;
      OP2_IMJ:  op2 = hold_imm_j;
      OP2_IMU:  op2 = hold_imm_u;
      default:  op2 = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= OPF_IDLE;
      hold_pc    <= '0;
      hold_inst  <= '0;
      hold_id    <= IID_X;
      hold_ctrl  <= '0;
      hold_imm_i <= '0;
      hold_imm_s <= '0;
      hold_imm_j <= '0;
      hold_imm_u <= '0;
      hold_imm_z <= '0;
    end else begin
      state <= state_next;
      if (capture) begin
        hold_pc    <= in_pc;
        hold_inst  <= in_inst;
        hold_id    <= in_inst_id;
        hold_ctrl  <= in_ctrl;
        hold_imm_i <= in_imm_i;
        hold_imm_s <= in_imm_s;
        hold_imm_j <= in_imm_j;
        hold_imm_u <= in_imm_u;
        hold_imm_z <= in_imm_z;
      end
    end
  end

  // Output register only changes on launch, so stalled outputs stay stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_inst    <= '0;
      out_inst_id <= IID_X;
      out_ctrl    <= '0;
      out_op1     <= '0;
      out_op2     <= '0;
      out_rs2     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (launch) begin
      out_valid   <= 1'b1;
      out_pc      <= hold_pc;
      out_inst    <= hold_inst;
      out_inst_id <= hold_id;
      out_ctrl    <= hold_ctrl;
      out_op1     <= op1;
      out_op2     <= op2;
      out_rs2     <= rs2_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef OPF_PERFCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (hazard) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: vector table through a
// scoreboard plus hand-written hazard, backpressure, flush and reset sequences.
module tb_operand_fetch_stage;
  import operand_fetch_stage_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, is_datahazard;
  logic [31:0] regfile [32];
  FwCtrl       fw [4];
  Addr         in_pc, out_pc;
  Inst         in_inst, out_inst;
  IId          in_inst_id, out_inst_id;
  Ctrl         in_ctrl, out_ctrl;
  logic [31:0] in_imm_i, in_imm_s, in_imm_j, in_imm_u, in_imm_z;
  logic [31:0] out_op1, out_op2, out_rs2;
`ifdef OPF_PERFCNT_EN
  logic [31:0] stall_cycles;
`endif

  operand_fetch_stage #(
    .XLEN    (32),
    .FW_NUM  (4),
    .REG_NUM (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .regfile       (regfile),
    .fw            (fw),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pc         (in_pc),
    .in_inst       (in_inst),
    .in_inst_id    (in_inst_id),
    .in_ctrl       (in_ctrl),
    .in_imm_i      (in_imm_i),
    .in_imm_s      (in_imm_s),
    .in_imm_j      (in_imm_j),
    .in_imm_u      (in_imm_u),
    .in_imm_z      (in_imm_z),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_inst      (out_inst),
    .out_inst_id   (out_inst_id),
    .out_ctrl      (out_ctrl),
    .out_op1       (out_op1),
    .out_op2       (out_op2),
    .out_rs2       (out_rs2),
    .is_datahazard (is_datahazard)
`ifdef OPF_PERFCNT_EN
    ,
    .stall_cycles  (stall_cycles)
`endif
  );

  typedef struct {
    Addr         pc;
    Inst         inst;
    IId          id;
    Ctrl         ctrl;
    logic [31:0] op1, op2, rs2;
  } exp_t;

  typedef struct {
    logic [4:0]  rs1, rs2;
    Op1Sel       s1;
    Op2Sel       s2;
    Addr         pc;
    logic [31:0] op1, op2, rs2d;
  } vec_t;

  exp_t sb [$];
  vec_t vecs [8];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   pops = 0;
  int   pop_cyc [64];
  int   cap_cyc = 0;
  IId   next_id = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic Inst mk_inst(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, 5'd1, 7'h13};
  endfunction

  // Scoreboard monitor: one transfer per negedge where valid & ready hold.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got id %h expected no output", out_inst_id);
      end else begin
        e = sb.pop_front();
        if (out_pc !== e.pc || out_inst !== e.inst || out_inst_id !== e.id ||
            out_ctrl !== e.ctrl || out_op1 !== e.op1 || out_op2 !== e.op2 ||
            out_rs2 !== e.rs2) begin
          errors++;
          $display("FAIL sb_data id=%h: got pc=%h op1=%h op2=%h rs2=%h id=%h expected pc=%h op1=%h op2=%h rs2=%h",
                   e.id, out_pc, out_op1, out_op2, out_rs2, out_inst_id, e.pc, e.op1, e.op2, e.rs2);
        end
      end
      if (pops < 64) pop_cyc[pops] = cyc;
      pops++;
    end
  end

  task automatic send(input logic [4:0] rs1, input logic [4:0] rs2, input Op1Sel s1,
                      input Op2Sel s2, input Addr pc, input logic [31:0] e1,
                      input logic [31:0] e2, input logic [31:0] er, input bit expect_out,
                      output int waited);
    exp_t e;
    in_pc      = pc;
    in_inst    = mk_inst(rs1, rs2);
    in_inst_id = next_id;
    in_ctrl    = '{op1_sel: s1, op2_sel: s2, fn: 4'h3};
    in_valid   = 1'b1;
    waited     = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
    end else if (expect_out) begin
      e.pc = pc; e.inst = in_inst; e.id = next_id; e.ctrl = in_ctrl;
      e.op1 = e1; e.op2 = e2; e.rs2 = er;
      sb.push_back(e);
    end
    cap_cyc = cyc;
    next_id++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fw();
    for (int unsigned k = 0; k < 4; k++) fw[k] = '0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int w;
    int base;
    int cap0;
    IId id_a;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_inst = '0; in_inst_id = '0; in_ctrl = '0;
    in_imm_i = 32'd5; in_imm_s = 32'h22; in_imm_j = 32'h33;
    in_imm_u = 32'h0004_4000; in_imm_z = 32'h1F;
    for (int unsigned i = 0; i < 32; i++) regfile[i] = 32'h0100_0000 + i;
    regfile[2] = 32'd7;
    clear_fw();

    vecs[0] = '{rs1: 5'd2,  rs2: 5'd0,  s1: OP1_RS1, s2: OP2_IMI,  pc: 32'h100,
                op1: 32'd7,          op2: 32'd5,          rs2d: 32'h0100_0000};
    vecs[1] = '{rs1: 5'd4,  rs2: 5'd6,  s1: OP1_RS1, s2: OP2_RS2W, pc: 32'h104,
                op1: 32'h0100_0004,  op2: 32'h0100_0006,  rs2d: 32'h0100_0006};
    vecs[2] = '{rs1: 5'd7,  rs2: 5'd9,  s1: OP1_PC,  s2: OP2_IMS,  pc: 32'h108,
                op1: 32'h108,        op2: 32'h22,         rs2d: 32'h0100_0009};
    vecs[3] = '{rs1: 5'd1,  rs2: 5'd2,  s1: OP1_IMZ, s2: OP2_IMJ,  pc: 32'h10C,
                op1: 32'h1F,         op2: 32'h33,         rs2d: 32'd7};
    vecs[4] = '{rs1: 5'd31, rs2: 5'd30, s1: OP1_RS1, s2: OP2_IMU,  pc: 32'h110,
                op1: 32'h0100_001F,  op2: 32'h0004_4000,  rs2d: 32'h0100_001E};
    vecs[5] = '{rs1: 5'd0,  rs2: 5'd8,  s1: OP1_RS1, s2: OP2_RS2W, pc: 32'h114,
                op1: 32'h0100_0000,  op2: 32'h0100_0008,  rs2d: 32'h0100_0008};
    vecs[6] = '{rs1: 5'd10, rs2: 5'd11, s1: OP1_X,   s2: OP2_X,    pc: 32'h118,
                op1: 32'd0,          op2: 32'd0,          rs2d: 32'h0100_000B};
    vecs[7] = '{rs1: 5'd12, rs2: 5'd0,  s1: OP1_PC,  s2: OP2_RS2W, pc: 32'h11C,
                op1: 32'h11C,        op2: 32'h0100_0000,  rs2d: 32'h0100_0000};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_op1", out_op1, 32'd0);
    check("rst_out_id", 32'(out_inst_id), 32'(IID_X));
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_hazard", 32'(is_datahazard), 32'd0);
`ifdef OPF_PERFCNT_EN
    check("rst_stall", stall_cycles, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Vector table, back-to-back
    base = pops;
    cap0 = 0;
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].rs1, vecs[i].rs2, vecs[i].s1, vecs[i].s2, vecs[i].pc,
           vecs[i].op1, vecs[i].op2, vecs[i].rs2d, 1'b1, w);
      if (i == 0) cap0 = cap_cyc;
      check("tput_wait", 32'(w), 32'd0);
    end
    drain("vec_drain");
    check("latency", 32'(pop_cyc[base]), 32'(cap0 + 2));
    check("tput_span", 32'(pop_cyc[base + 7] - pop_cyc[base]), 32'd7);

    // Forwarding priority
    fw[2] = '{valid: 1'b1, addr: 5'd3, fwdable: 1'b1, wdata: 32'hAA};
    fw[0] = '{valid: 1'b1, addr: 5'd3, fwdable: 1'b1, wdata: 32'h55};
    send(5'd3, 5'd0, OP1_RS1, OP2_X, 32'h200, 32'h55, 32'd0, 32'h0100_0000, 1'b1, w);
    drain("prio_fw0");
    fw[0].valid = 1'b0;
    send(5'd3, 5'd0, OP1_RS1, OP2_X, 32'h204, 32'hAA, 32'd0, 32'h0100_0000, 1'b1, w);
    drain("prio_fw2");
    clear_fw();

    // x0 never matches a forwarding source
    fw[0] = '{valid: 1'b1, addr: 5'd0, fwdable: 1'b0, wdata: 32'hBAD};
    send(5'd0, 5'd8, OP1_RS1, OP2_RS2W, 32'h280, 32'h0100_0000, 32'h0100_0008,
         32'h0100_0008, 1'b1, w);
    @(negedge clk);
    check("x0_no_hazard", 32'(is_datahazard), 32'd0);
    drain("x0_drain");
    clear_fw();

    // Three-cycle hazard on rs2, then forwarded data
    fw[0] = '{valid: 1'b1, addr: 5'd5, fwdable: 1'b0, wdata: 32'd0};
    send(5'd1, 5'd5, OP1_RS1, OP2_RS2W, 32'h300, 32'h0100_0001, 32'h10, 32'h10, 1'b1, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("haz_active", 32'(is_datahazard), 32'd1);
      check("haz_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    fw[0].fwdable = 1'b1;
    fw[0].wdata   = 32'h10;
    @(negedge clk);
    check("haz_cleared", 32'(is_datahazard), 32'd0);
    drain("haz_drain");
`ifdef OPF_PERFCNT_EN
    check("stall_count", stall_cycles, 32'd3);
`endif
    clear_fw();

    // Output backpressure with two instructions
    out_ready = 1'b0;
    id_a = next_id;
    send(5'd4, 5'd6, OP1_RS1, OP2_RS2W, 32'h400, 32'h0100_0004, 32'h0100_0006,
         32'h0100_0006, 1'b1, w);
    send(5'd7, 5'd9, OP1_PC, OP2_IMI, 32'h404, 32'h404, 32'd5, 32'h0100_0009, 1'b1, w);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_id", 32'(out_inst_id), 32'(id_a));
      check("bp_op1", out_op1, 32'h0100_0004);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drain("bp_drain");

    // Flush during a hazard with a simultaneous offer
    fw[0] = '{valid: 1'b1, addr: 5'd5, fwdable: 1'b0, wdata: 32'd0};
    send(5'd1, 5'd5, OP1_RS1, OP2_RS2W, 32'h500, 32'd0, 32'd0, 32'd0, 1'b0, w);
    in_inst = mk_inst(5'd2, 5'd5); in_pc = 32'h504; in_inst_id = next_id;
    in_valid = 1'b1; flush = 1'b1;
    next_id++;
    @(negedge clk);
    check("flush_pre_haz", 32'(is_datahazard), 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_no_capture", 32'(is_datahazard), 32'd0);
    clear_fw();
    repeat (3) @(negedge clk);
    check("flush_quiet", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Reset mid-stall with a simultaneous offer
    fw[0] = '{valid: 1'b1, addr: 5'd5, fwdable: 1'b0, wdata: 32'd0};
    send(5'd1, 5'd5, OP1_RS1, OP2_RS2W, 32'h600, 32'd0, 32'd0, 32'd0, 1'b0, w);
    in_inst = mk_inst(5'd2, 5'd5); in_pc = 32'h604; in_inst_id = next_id;
    in_valid = 1'b1; rst_n = 1'b0;
    next_id++;
    @(negedge clk);
    check("rstm_pre_haz", 32'(is_datahazard), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("rstm_out_valid", 32'(out_valid), 32'd0);
    check("rstm_in_ready", 32'(in_ready), 32'd1);
    check("rstm_no_capture", 32'(is_datahazard), 32'd0);
    check("rstm_out_id", 32'(out_inst_id), 32'(IID_X));
`ifdef OPF_PERFCNT_EN
    check("rstm_stall", stall_cycles, 32'd0);
`endif
    clear_fw();
    repeat (3) @(negedge clk);
    check("rstm_quiet", 32'(out_valid), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
